// File: rtl/cprv_pkg.sv
// Shared constants, entry types and the doubleword half-select for the fetch unit.
package cprv_pkg;
  localparam int XLEN        = 64;
  localparam int INSTR_WIDTH = 32;
  localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;
  // Wide enough for any practical MAX_OUTSTANDING; the top only compares its low bits.
  localparam int EPOCH_MAX_W = 8;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic [EPOCH_MAX_W-1:0] epoch;
    logic [XLEN-1:0]        pc;
  } pend_entry_t;

  function automatic logic [INSTR_WIDTH-1:0] sel_half(input logic [XLEN-1:0] pc,
                                                      input logic [XLEN-1:0] dw);
    return pc[2] ? dw[2*INSTR_WIDTH-1:INSTR_WIDTH] : dw[INSTR_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/cprv_sync_fifo.sv
// Synchronous FIFO with clear; head is read straight from the storage registers.
module cprv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            data_i,
  input  logic                        pop_i,
  input  logic                        clear_i,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(DEPTH+1)-1:0]  count_o,
  output logic [WIDTH-1:0]            head_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               rd_q, wr_q;
  logic [CW-1:0]               cnt_q;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= nxt(wr_q);
      end
      if (pop_i) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
endmodule

// File: rtl/cprv_fetch_unit.sv
// Pipelined instruction fetch: credit-limited imem requests, epoch-tagged
// pending list and a fetch queue feeding ID.
module cprv_fetch_unit
  import cprv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = cprv_pkg::RESET_PC,
  parameter int              FQ_DEPTH        = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   redirect_valid_i,
  input  logic [XLEN-1:0]        redirect_pc_i,
  output logic                   valid_imem_o,
  input  logic                   ready_imem_i,
  output logic [XLEN-1:0]        instr_addr_imem_o,
  input  logic                   valid_resp_i,
  output logic                   ready_resp_o,
  input  logic [XLEN-1:0]        instr_data_imem_i,
  output logic                   valid_id_o,
  input  logic                   ready_id_i,
  output logic [INSTR_WIDTH-1:0] instr_data_id_o,
  output logic [XLEN-1:0]        instr_pc_id_o
);
  localparam int EPW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(FQ_DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [EPW-1:0]  epoch_q, epoch_d;
  logic            run_q;

  pend_entry_t  pend_in, pend_head;
  fetch_entry_t fq_in, fq_head;
  logic         pend_full, pend_empty, fq_full, fq_empty;
  logic [PCW-1:0] pend_cnt;
  logic [FCW-1:0] fq_cnt;
  logic credit, req_hs, resp_hs, resp_keep, id_hs;

  // Every outstanding request owns a queue slot, so a response can always be accepted.
  assign credit = run_q
               && ((32'(pend_cnt) + 32'(fq_cnt)) < 32'(FQ_DEPTH))
               && (32'(pend_cnt) < 32'(MAX_OUTSTANDING));

  assign valid_imem_o      = credit & ~redirect_valid_i;
  assign instr_addr_imem_o = {pc_q[XLEN-1:3], 3'b000};
  assign ready_resp_o      = 1'b1;

  assign req_hs    = valid_imem_o & ready_imem_i;
  assign resp_hs   = valid_resp_i;
  assign resp_keep = resp_hs && !redirect_valid_i
                  && (pend_head.epoch == EPOCH_MAX_W'(epoch_q));
  assign id_hs     = valid_id_o & ready_id_i;

  assign pend_in = '{epoch: EPOCH_MAX_W'(epoch_q), pc: pc_q};
  assign fq_in   = '{pc: pend_head.pc, instr: sel_half(pend_head.pc, instr_data_imem_i)};

  always_comb begin
    pc_d    = pc_q;
    epoch_d = epoch_q;
    if (redirect_valid_i) begin
      pc_d    = redirect_pc_i & ~XLEN'(3);
      epoch_d = epoch_q + EPW'(1);
    end else if (req_hs) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  // run_q holds off the first request until the cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      epoch_q <= '0;
      run_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      run_q   <= 1'b1;
    end
  end

  cprv_sync_fifo #(.WIDTH($bits(pend_entry_t)), .DEPTH(MAX_OUTSTANDING)) u_pend (
    .clk(clk), .rst_n(rst_n),
    .push_i(req_hs), .data_i(pend_in), .pop_i(resp_hs), .clear_i(1'b0),
    .full_o(pend_full), .empty_o(pend_empty), .count_o(pend_cnt), .head_o(pend_head)
  );

  cprv_sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FQ_DEPTH)) u_fq (
    .clk(clk), .rst_n(rst_n),
    .push_i(resp_keep), .data_i(fq_in), .pop_i(id_hs), .clear_i(redirect_valid_i),
    .full_o(fq_full), .empty_o(fq_empty), .count_o(fq_cnt), .head_o(fq_head)
  );

  assign valid_id_o      = ~fq_empty;
  assign instr_data_id_o = fq_head.instr;
  assign instr_pc_id_o   = fq_head.pc;

  a_resp_has_pending: assert property (@(posedge clk) disable iff (!rst_n)
    valid_resp_i |-> !pend_empty);
  a_no_push_full_fq: assert property (@(posedge clk) disable iff (!rst_n)
    resp_keep |-> !fq_full);
  a_no_push_full_pend: assert property (@(posedge clk) disable iff (!rst_n)
    req_hs |-> !pend_full);
endmodule

// File: tb/tb_cprv_fetch_unit.sv
// Directed bench for cprv_fetch_unit with an in-order imem model of configurable latency.
module tb_cprv_fetch_unit;
  logic        clk;
  logic        rst_n;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        valid_imem_o;
  logic        ready_imem_i;
  logic [63:0] instr_addr_imem_o;
  logic        valid_resp_i;
  logic        ready_resp_o;
  logic [63:0] instr_data_imem_i;
  logic        valid_id_o;
  logic        ready_id_i;
  logic [31:0] instr_data_id_o;
  logic [63:0] instr_pc_id_o;

  int n_cmp = 0;
  int n_err = 0;

  cprv_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .valid_imem_o(valid_imem_o), .ready_imem_i(ready_imem_i),
    .instr_addr_imem_o(instr_addr_imem_o),
    .valid_resp_i(valid_resp_i), .ready_resp_o(ready_resp_o),
    .instr_data_imem_i(instr_data_imem_i),
    .valid_id_o(valid_id_o), .ready_id_i(ready_id_i),
    .instr_data_id_o(instr_data_id_o), .instr_pc_id_o(instr_pc_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // imem model: data word encodes its own address in both halves
  typedef struct { logic [63:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int    rsp_delay = 1;

  function automatic logic [63:0] mem_data(input logic [63:0] a);
    return {a[31:0] ^ 32'h2222_2222, a[31:0] ^ 32'h1111_1111};
  endfunction

  function automatic logic [31:0] exp_instr(input logic [63:0] pc);
    logic [31:0] a;
    a = {pc[31:3], 3'b000};
    return pc[2] ? (a ^ 32'h2222_2222) : (a ^ 32'h1111_1111);
  endfunction

  initial begin
    logic        m_req, m_rsp;
    logic [63:0] m_addr;
    int          mcyc;
    valid_resp_i      = 1'b0;
    instr_data_imem_i = '0;
    mcyc = 0;
    forever begin
      @(negedge clk);
      m_req  = valid_imem_o && ready_imem_i;
      m_addr = instr_addr_imem_o;
      m_rsp  = valid_resp_i && ready_resp_o;
      @(posedge clk); #1;
      mcyc++;
      if (!rst_n) mq.delete();
      else begin
        if (m_rsp && mq.size() > 0) void'(mq.pop_front());
        if (m_req) mq.push_back('{addr: m_addr, due: mcyc + rsp_delay - 1});
      end
      if (mq.size() > 0 && mq[0].due <= mcyc) begin
        valid_resp_i      = 1'b1;
        instr_data_imem_i = mem_data(mq[0].addr);
      end else begin
        valid_resp_i      = 1'b0;
        instr_data_imem_i = '0;
      end
    end
  end

  logic [63:0] req_log[$];
  logic [63:0] pc_log[$];
  logic [31:0] in_log[$];
  logic        vid_log[$];
  int          cyc_idx;
  int          first_req_cyc;

  task automatic clear_logs();
    req_log.delete(); pc_log.delete(); in_log.delete(); vid_log.delete();
    cyc_idx = 0; first_req_cyc = -1;
  endtask

  // Called at posedge+1; covers exactly one cycle and returns at the next posedge+1.
  task automatic run_cycle(input bit redir, input logic [63:0] rpc);
    redirect_valid_i = redir;
    redirect_pc_i    = rpc;
    @(negedge clk);
    vid_log.push_back(valid_id_o);
    if (valid_imem_o && ready_imem_i) begin
      req_log.push_back(instr_addr_imem_o);
      if (first_req_cyc < 0) first_req_cyc = cyc_idx;
    end
    if (valid_id_o && ready_id_i) begin
      pc_log.push_back(instr_pc_id_o);
      in_log.push_back(instr_data_id_o);
    end
    @(posedge clk); #1;
    redirect_valid_i = 1'b0;
    cyc_idx++;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    redirect_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (valid_imem_o !== 1'b0) begin n_err++; $display("FAIL reset_valid_imem got %b exp 0", valid_imem_o); end
    n_cmp++; if (valid_id_o !== 1'b0) begin n_err++; $display("FAIL reset_valid_id got %b exp 0", valid_id_o); end
    n_cmp++; if (instr_data_id_o !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h exp 0", instr_data_id_o); end
    n_cmp++; if (instr_pc_id_o !== 64'h0) begin n_err++; $display("FAIL reset_pc got %h exp 0", instr_pc_id_o); end
  endtask

  task automatic test_stream();
    ready_imem_i = 1'b1; ready_id_i = 1'b1; rsp_delay = 1;
    do_reset();
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 64'h0);
    n_cmp++; if (first_req_cyc !== 1) begin n_err++; $display("FAIL stream_first_req_cycle got %0d exp 1", first_req_cyc); end
    n_cmp++; if (vid_log[2] !== 1'b0) begin n_err++; $display("FAIL stream_vid_c2 got %b exp 0", vid_log[2]); end
    n_cmp++; if (vid_log[3] !== 1'b1) begin n_err++; $display("FAIL stream_vid_c3 got %b exp 1", vid_log[3]); end
    n_cmp++; if (req_log[0] !== 64'h8000_0000) begin n_err++; $display("FAIL stream_req0 got %h exp 80000000", req_log[0]); end
    n_cmp++; if (req_log[1] !== 64'h8000_0000) begin n_err++; $display("FAIL stream_req1 got %h exp 80000000", req_log[1]); end
    n_cmp++; if (req_log[2] !== 64'h8000_0008) begin n_err++; $display("FAIL stream_req2 got %h exp 80000008", req_log[2]); end
    n_cmp++; if (pc_log[0] !== 64'h8000_0000) begin n_err++; $display("FAIL stream_pc0 got %h exp 80000000", pc_log[0]); end
    n_cmp++; if (pc_log[1] !== 64'h8000_0004) begin n_err++; $display("FAIL stream_pc1 got %h exp 80000004", pc_log[1]); end
    n_cmp++; if (pc_log[2] !== 64'h8000_0008) begin n_err++; $display("FAIL stream_pc2 got %h exp 80000008", pc_log[2]); end
    n_cmp++; if (in_log[0] !== 32'h9111_1111) begin n_err++; $display("FAIL stream_instr0 got %h exp 91111111", in_log[0]); end
    n_cmp++; if (in_log[1] !== 32'hA222_2222) begin n_err++; $display("FAIL stream_instr1 got %h exp a2222222", in_log[1]); end
    n_cmp++; if (in_log[2] !== 32'h9111_1119) begin n_err++; $display("FAIL stream_instr2 got %h exp 91111119", in_log[2]); end
    n_cmp++; if (pc_log.size() !== 7) begin n_err++; $display("FAIL stream_throughput got %0d exp 7", pc_log.size()); end
  endtask

  task automatic test_backpressure();
    ready_imem_i = 1'b1; ready_id_i = 1'b0; rsp_delay = 1;
    do_reset();
    for (int i = 0; i < 12; i++) run_cycle(1'b0, 64'h0);
    n_cmp++; if (req_log.size() !== 4) begin n_err++; $display("FAIL bp_req_count got %0d exp 4", req_log.size()); end
    n_cmp++; if (valid_imem_o !== 1'b0) begin n_err++; $display("FAIL bp_valid_imem_full got %b exp 0", valid_imem_o); end
    n_cmp++; if (vid_log[11] !== 1'b1) begin n_err++; $display("FAIL bp_vid_held got %b exp 1", vid_log[11]); end
    ready_id_i = 1'b1;
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 64'h0);
    n_cmp++; if (pc_log.size() !== 10) begin n_err++; $display("FAIL bp_pop_count got %0d exp 10", pc_log.size()); end
    for (int k = 0; k < 10; k++) begin
      logic [63:0] epc;
      epc = 64'h8000_0000 + 64'(4 * k);
      n_cmp++; if (pc_log[k] !== epc) begin n_err++; $display("FAIL bp_pc[%0d] got %h exp %h", k, pc_log[k], epc); end
      n_cmp++; if (in_log[k] !== exp_instr(epc)) begin n_err++; $display("FAIL bp_instr[%0d] got %h exp %h", k, in_log[k], exp_instr(epc)); end
    end
  endtask

  task automatic test_redirect_stale();
    ready_imem_i = 1'b1; ready_id_i = 1'b1; rsp_delay = 3;
    do_reset();
    for (int i = 0; i < 14; i++) run_cycle(i == 3, 64'h8000_0100);
    n_cmp++; if (req_log[1] !== 64'h8000_0000) begin n_err++; $display("FAIL stale_req1 got %h exp 80000000", req_log[1]); end
    n_cmp++; if (req_log[2] !== 64'h8000_0100) begin n_err++; $display("FAIL stale_req_after_redirect got %h exp 80000100", req_log[2]); end
    n_cmp++; if (vid_log[4] !== 1'b0) begin n_err++; $display("FAIL stale_vid_after_redirect got %b exp 0", vid_log[4]); end
    n_cmp++; if (pc_log[0] !== 64'h8000_0100) begin n_err++; $display("FAIL stale_first_pc got %h exp 80000100", pc_log[0]); end
    n_cmp++; if (in_log[0] !== 32'h9111_1011) begin n_err++; $display("FAIL stale_first_instr got %h exp 91111011", in_log[0]); end
    n_cmp++; if (pc_log[1] !== 64'h8000_0104) begin n_err++; $display("FAIL stale_second_pc got %h exp 80000104", pc_log[1]); end
    rsp_delay = 1;
  endtask

  task automatic test_redirect_collision();
    ready_imem_i = 1'b1; ready_id_i = 1'b1; rsp_delay = 1;
    do_reset();
    for (int i = 0; i < 10; i++) run_cycle(i == 5, 64'h8000_0100);
    n_cmp++; if (pc_log[2] !== 64'h8000_0008) begin n_err++; $display("FAIL coll_consumed_pc got %h exp 80000008", pc_log[2]); end
    n_cmp++; if (pc_log[3] !== 64'h8000_0100) begin n_err++; $display("FAIL coll_next_pc got %h exp 80000100", pc_log[3]); end
    n_cmp++; if (in_log[3] !== 32'h9111_1011) begin n_err++; $display("FAIL coll_next_instr got %h exp 91111011", in_log[3]); end
    n_cmp++; if (vid_log[6] !== 1'b0) begin n_err++; $display("FAIL coll_flush got %b exp 0", vid_log[6]); end
    n_cmp++; if (req_log[4] !== 64'h8000_0100) begin n_err++; $display("FAIL coll_next_req got %h exp 80000100", req_log[4]); end
  endtask

  task automatic test_redirect_misaligned();
    ready_imem_i = 1'b1; ready_id_i = 1'b0; rsp_delay = 1;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      if (i == 8) ready_id_i = 1'b1;
      run_cycle(i == 7, 64'h8000_0106);
    end
    n_cmp++; if (vid_log[7] !== 1'b1) begin n_err++; $display("FAIL mis_full_before got %b exp 1", vid_log[7]); end
    n_cmp++; if (vid_log[8] !== 1'b0) begin n_err++; $display("FAIL mis_flush got %b exp 0", vid_log[8]); end
    n_cmp++; if (req_log[4] !== 64'h8000_0100) begin n_err++; $display("FAIL mis_req_addr got %h exp 80000100", req_log[4]); end
    n_cmp++; if (pc_log[0] !== 64'h8000_0104) begin n_err++; $display("FAIL mis_pc got %h exp 80000104", pc_log[0]); end
    n_cmp++; if (in_log[0] !== 32'hA222_2322) begin n_err++; $display("FAIL mis_instr got %h exp a2222322", in_log[0]); end
    n_cmp++; if (pc_log[1] !== 64'h8000_0108) begin n_err++; $display("FAIL mis_pc1 got %h exp 80000108", pc_log[1]); end
  endtask

  task automatic test_reset_midstream();
    ready_imem_i = 1'b1; ready_id_i = 1'b0; rsp_delay = 1;
    do_reset();
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 64'h0);
    n_cmp++; if (valid_id_o !== 1'b1) begin n_err++; $display("FAIL mid_vid_before got %b exp 1", valid_id_o); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (valid_id_o !== 1'b0) begin n_err++; $display("FAIL mid_vid_drop got %b exp 0", valid_id_o); end
    n_cmp++; if (valid_imem_o !== 1'b0) begin n_err++; $display("FAIL mid_vimem_drop got %b exp 0", valid_imem_o); end
    n_cmp++; if (instr_pc_id_o !== 64'h0) begin n_err++; $display("FAIL mid_pc_clear got %h exp 0", instr_pc_id_o); end
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    ready_id_i = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 64'h0);
    n_cmp++; if (first_req_cyc !== 1) begin n_err++; $display("FAIL mid_first_req_cycle got %0d exp 1", first_req_cyc); end
    n_cmp++; if (req_log[0] !== 64'h8000_0000) begin n_err++; $display("FAIL mid_restart_addr got %h exp 80000000", req_log[0]); end
    n_cmp++; if (pc_log[0] !== 64'h8000_0000) begin n_err++; $display("FAIL mid_restart_pc got %h exp 80000000", pc_log[0]); end
    n_cmp++; if (in_log[0] !== 32'h9111_1111) begin n_err++; $display("FAIL mid_restart_instr got %h exp 91111111", in_log[0]); end
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i = 64'h0;
    ready_imem_i = 1'b1;
    ready_id_i = 1'b1;
    clear_logs();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_collision();
    test_redirect_misaligned();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cprv_fetch_unit.md
Name: cprv_fetch_unit

Overview:
- Parametrised successor of the single-entry IF stage.
- Owns the PC, issues pipelined instruction-memory requests with up to MAX_OUTSTANDING in flight, and buffers returned instructions in an FQ_DEPTH fetch queue.
- Supports redirect/flush from EX with epoch-based discard of stale responses.
- Sits between the imem port and the ID stage; all interfaces are valid/ready.

Parameters:
XLEN, 64, address and imem data width
INSTR_WIDTH, 32, instruction width
RESET_PC, 64'h0000_0000_8000_0000, PC value after reset
FQ_DEPTH, 4, fetch-queue entries (power of 2, >=2)
MAX_OUTSTANDING, 2, imem requests in flight (power of 2, >=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
redirect_valid_i  in  1  flush and redirect the PC (single-cycle pulse)
redirect_pc_i  in  XLEN  new PC; bits [1:0] ignored
valid_imem_o  out  1  imem request valid
ready_imem_i  in  1  imem request accepted
instr_addr_imem_o  out  XLEN  request address, always 8-byte aligned (pc with [2:0] zeroed)
valid_resp_i  in  1  imem response valid (responses return in order)
ready_resp_o  out  1  tied high; credit scheme guarantees space
instr_data_imem_i  in  XLEN  response doubleword
valid_id_o  out  1  queue head valid
ready_id_i  in  1  ID accepts
instr_data_id_o  out  INSTR_WIDTH  head instruction
instr_pc_id_o  out  XLEN  head PC

Behaviour:
- Reset (rst_n=0, async): pc=RESET_PC, epoch=0, queue and pending list empty. valid_imem_o=0, valid_id_o=0, instr_data_id_o=0, instr_pc_id_o=0.
- Credit: issue allowed when pending_cnt + fq_cnt < FQ_DEPTH and pending_cnt < MAX_OUTSTANDING.
- valid_imem_o = credit & ~redirect_valid_i (combinational). Valid is not required to stay asserted without ready.
- Request handshake (valid & ready): push {epoch, pc} into the pending FIFO; pc += 4 (XLEN wrap-around allowed).
- Response handshake:
  - Pop the pending FIFO.
  - If the entry epoch == current epoch and no redirect this cycle: select instr = entry.pc[2] ? data[63:32] : data[31:0], then push {pc, instr} into the fetch queue.
  - Otherwise drop the response; it is still counted as returned.
- A response with an empty pending FIFO is illegal; flag it with an assertion.
- ID side: valid_id_o = ~fq_empty. Outputs are registered from the queue head. Handshake pops the head.
- Latency:
  - Response at cycle t appears on valid_id_o at t+1.
  - First request after reset release is issued at cycle 1.
  - Steady state with imem ready every cycle and 1-cycle response: one instruction per cycle.
- Redirect, effective at the clock edge:
  - pc <= {redirect_pc_i[XLEN-1:2], 2'b00}.
  - epoch toggles.
  - Fetch queue cleared; valid_id_o=0 the next cycle.
  - Pending entries are kept so their responses drain and are dropped.
  - Request issue resumes the next cycle at the new PC.
- Simultaneous events:
  - Redirect with an ID handshake: the handshake completes, then the flush.
  - Redirect with a response: the response is dropped.
  - Push and pop on the same queue in the same cycle: both happen; count unchanged.
  - Full queue: credit is 0, so a push to a full queue cannot occur; assert this.
- Back-to-back redirects: epoch toggles each time. A 1-bit epoch is sufficient only because each redirect is followed by draining. Epoch width is clog2(MAX_OUTSTANDING)+1 bits, compared for equality.
- Reset asserted mid-operation: all state returns to reset values immediately. In-flight imem responses after reset release are illegal (the system resets imem together with this block).

Decomposition:
- Shared package cprv_pkg:
  - XLEN, INSTR_WIDTH, RESET_PC.
  - typedef fetch_entry_t {pc, instr}.
  - typedef pend_entry_t {epoch, pc}.
- Sub-module cprv_sync_fifo: parametrised WIDTH/DEPTH; push, pop, clear, full, empty, count; registered head output; async active-low reset. Instantiated twice: pending FIFO (MAX_OUTSTANDING) and fetch queue (FQ_DEPTH).

Test Plan:
- Release reset, imem always ready, 1-cycle response:
  - Request addresses 0x8000_0000, 0x8000_0000, 0x8000_0008.
  - ID receives PCs 0x8000_0000, 0x8000_0004, 0x8000_0008 with instrs data[31:0], data[63:32], data[31:0].
  - valid_id_o first high 2 cycles after the first request.
- Hold ready_id_i=0:
  - Exactly FQ_DEPTH=4 instructions are fetched, then valid_imem_o stays 0.
  - Raise ready_id_i: one pop per cycle and issue resumes; no instruction lost or duplicated.
- Response delay 3 cycles with 2 requests in flight, redirect to 0x8000_0100:
  - Both stale responses are dropped.
  - First ID instruction has PC 0x8000_0100; queue flushed the cycle after the redirect.
- Redirect in the same cycle as an ID handshake and a response:
  - The handshaked instruction counts as consumed.
  - The response is dropped.
  - Next fetch address is 0x8000_0100.
- Redirect to 0x8000_0106:
  - Low bits ignored; PC 0x8000_0104; request address 0x8000_0100; upper half selected.
- Assert rst_n low mid-stream with the queue at 3 entries:
  - valid_id_o and valid_imem_o drop immediately.
  - After release, fetch restarts at RESET_PC.
